// File: rtl/exception_vector_fetch_pkg.sv
// Shared exception definitions: cause codes, FSM states and the default vector base.
// Also imported by the address mux and the control unit.
package exception_vector_fetch_pkg;

    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h253;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OVF  = 2'd1;
    localparam logic [1:0] CAUSE_DIVZ = 2'd2;
    localparam logic [1:0] CAUSE_OPC  = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StWait   = 2'd2,
        StCommit = 2'd3
    } state_e;

    // Cause k lives at base + k - 1.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [1:0] code);
        return base + {30'b0, code} - 32'd1;
    endfunction

endpackage

// File: rtl/exception_vector_fetch_exc_priority_encoder.sv
// Combinational 3-request to 2-bit cause encoder; overflow > div_zero > bad_opcode.
module exc_priority_encoder
    import exception_vector_fetch_pkg::*;
(
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       bad_opcode,
    output logic [1:0] cause,
    output logic       valid
);

    always_comb begin
        cause = CAUSE_NONE;
        if (overflow) begin
            cause = CAUSE_OVF;
        end else if (div_zero) begin
            cause = CAUSE_DIVZ;
        end else if (bad_opcode) begin
            cause = CAUSE_OPC;
        end
    end

    assign valid = overflow | div_zero | bad_opcode;

endmodule

// File: rtl/exception_vector_fetch.sv
// Exception front-end: latches cause/EPC, reads the vector byte from memory and
// writes the zero-extended handler address into the PC.
module exception_vector_fetch
    import exception_vector_fetch_pkg::*;
#(
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEFAULT,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic        bad_opcode,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc_out,
    output logic        epc_we,
    output logic [31:0] pc_out,
    output logic        pc_we,
    output logic [1:0]  cause,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    state_e      r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_mem_addr;
    logic        r_mem_rd;
    logic [31:0] r_epc;
    logic        r_epc_we;
    logic [31:0] r_pc;
    logic        r_pc_we;
    logic [1:0]  r_cause;
    logic        r_busy;

    logic [1:0]  w_code;
    logic        w_req;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^mem_rdata[23:0];

    exc_priority_encoder u_enc (
        .overflow   (overflow),
        .div_zero   (div_zero),
        .bad_opcode (bad_opcode),
        .cause      (w_code),
        .valid      (w_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_wait_cnt <= 4'd0;
            r_mem_addr <= 32'd0;
            r_mem_rd   <= 1'b0;
            r_epc      <= 32'd0;
            r_epc_we   <= 1'b0;
            r_pc       <= 32'd0;
            r_pc_we    <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_cause    <= w_code;
                        r_epc      <= pc_in - 32'd4;
                        r_mem_addr <= vec_addr(VEC_BASE, w_code);
                        r_busy     <= 1'b1;
                        // Strobes are registered so they appear during the REQ cycle.
                        r_mem_rd   <= 1'b1;
                        r_epc_we   <= 1'b1;
                        r_state    <= StReq;
                    end
                end
                StReq: begin
                    r_mem_rd   <= 1'b0;
                    r_epc_we   <= 1'b0;
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= StWait;
                end
                StWait: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_pc    <= {24'b0, mem_rdata[31:24]};
                        r_pc_we <= 1'b1;
                        r_state <= StCommit;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                StCommit: begin
                    r_pc_we <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign epc_out  = r_epc;
    assign epc_we   = r_epc_we;
    assign pc_out   = r_pc;
    assign pc_we    = r_pc_we;
    assign cause    = r_cause;
    assign busy     = r_busy;

endmodule

// File: tb/tb_exception_vector_fetch.sv
// Bench for exception_vector_fetch: default-latency and MEM_LATENCY=3 instances,
// checked cycle by cycle against a timing/arithmetic model of the exception sequence.
module tb_exception_vector_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        overflow = 1'b0, div_zero = 1'b0, bad_opcode = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_rdata_a = 32'd0, mem_rdata_b = 32'd0;

    logic [31:0] a_mem_addr, a_epc_out, a_pc_out, b_mem_addr, b_epc_out, b_pc_out;
    logic        a_mem_rd, a_epc_we, a_pc_we, a_busy, b_mem_rd, b_epc_we, b_pc_we, b_busy;
    logic [1:0]  a_cause, b_cause;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exception_vector_fetch u_dut_a (
        .clk(clk), .reset_n(reset_n), .overflow(overflow), .div_zero(div_zero),
        .bad_opcode(bad_opcode), .pc_in(pc_in), .mem_rdata(mem_rdata_a),
        .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .epc_out(a_epc_out), .epc_we(a_epc_we),
        .pc_out(a_pc_out), .pc_we(a_pc_we), .cause(a_cause), .busy(a_busy)
    );

    exception_vector_fetch #(.MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .overflow(overflow), .div_zero(div_zero),
        .bad_opcode(bad_opcode), .pc_in(pc_in), .mem_rdata(mem_rdata_b),
        .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .epc_out(b_epc_out), .epc_we(b_epc_we),
        .pc_out(b_pc_out), .pc_we(b_pc_we), .cause(b_cause), .busy(b_busy)
    );

    wire [101:0] a_all = {a_mem_addr, a_mem_rd, a_epc_out, a_epc_we, a_pc_out, a_pc_we,
                          a_cause, a_busy};
    wire [101:0] b_all = {b_mem_addr, b_mem_rd, b_epc_out, b_epc_we, b_pc_out, b_pc_we,
                          b_cause, b_busy};

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((a_busy || b_busy) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (a_busy || b_busy) begin
            n_fail++;
            $display("FAIL %s idle: busy_a=%b busy_b=%b, expected both 0 within 20 cycles",
                     tag, a_busy, b_busy);
        end
    endtask

    // One full exception on instance A (latency 1) or B (latency 3), checked every cycle.
    task automatic run_exc(input logic ovf, input logic dz, input logic opc,
                           input logic [31:0] pc, input logic [7:0] vbyte,
                           input bit use_b, input bit pulse, input string tag);
        int          lat;
        logic [1:0]  exp_cause;
        logic [31:0] exp_addr, exp_epc, exp_pc, rd;
        logic [31:0] o_addr, o_epc, o_pc;
        logic        o_rd, o_ewe, o_pwe, o_busy;
        logic [1:0]  o_cause;

        lat       = use_b ? 3 : 1;
        exp_cause = ovf ? 2'd1 : dz ? 2'd2 : 2'd3;
        exp_addr  = 32'h253 + 32'(exp_cause) - 32'd1;
        exp_epc   = pc - 32'd4;
        exp_pc    = 32'(vbyte);

        @(negedge clk);
        overflow = ovf; div_zero = dz; bad_opcode = opc; pc_in = pc;
        @(posedge clk); #1;
        overflow = 1'b0; div_zero = 1'b0; bad_opcode = 1'b0;
        pc_in = $urandom;
        for (int k = 1; k <= lat + 3; k++) begin
            // Only the final WAIT cycle carries the real vector byte.
            rd = {vbyte ^ 8'($urandom_range(1, 255)), 24'($urandom)};
            if (k == lat + 1) rd = {vbyte, 24'($urandom)};
            if (use_b) mem_rdata_b = rd; else mem_rdata_a = rd;
            overflow = pulse && (k >= 2) && (k <= lat + 2);
            @(negedge clk);
            o_addr  = use_b ? b_mem_addr : a_mem_addr;
            o_epc   = use_b ? b_epc_out  : a_epc_out;
            o_pc    = use_b ? b_pc_out   : a_pc_out;
            o_rd    = use_b ? b_mem_rd   : a_mem_rd;
            o_ewe   = use_b ? b_epc_we   : a_epc_we;
            o_pwe   = use_b ? b_pc_we    : a_pc_we;
            o_busy  = use_b ? b_busy     : a_busy;
            o_cause = use_b ? b_cause    : a_cause;

            n_tests++;
            if (o_rd !== 1'(k == 1)) begin
                n_fail++;
                $display("FAIL %s mem_rd cycle %0d: got %b want %b", tag, k, o_rd, k == 1);
            end
            n_tests++;
            if (o_ewe !== 1'(k == 1)) begin
                n_fail++;
                $display("FAIL %s epc_we cycle %0d: got %b want %b", tag, k, o_ewe, k == 1);
            end
            n_tests++;
            if (o_pwe !== 1'(k == lat + 2)) begin
                n_fail++;
                $display("FAIL %s pc_we cycle %0d: got %b want %b", tag, k, o_pwe,
                         k == lat + 2);
            end
            n_tests++;
            if (o_busy !== 1'(k <= lat + 2)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b want %b", tag, k, o_busy,
                         k <= lat + 2);
            end
            n_tests++;
            if (o_cause !== exp_cause) begin
                n_fail++;
                $display("FAIL %s cause cycle %0d: got %0d want %0d", tag, k, o_cause,
                         exp_cause);
            end
            n_tests++;
            if (o_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL %s mem_addr cycle %0d: got %h want %h", tag, k, o_addr,
                         exp_addr);
            end
            n_tests++;
            if (o_epc !== exp_epc) begin
                n_fail++;
                $display("FAIL %s epc_out cycle %0d: got %h want %h", tag, k, o_epc, exp_epc);
            end
            if (k >= lat + 2) begin
                n_tests++;
                if (o_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL %s pc_out cycle %0d: got %h want %h", tag, k, o_pc,
                             exp_pc);
                end
            end
            @(posedge clk); #1;
        end
        overflow = 1'b0;
        wait_idle(tag);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_tests++;
        if (a_all !== '0 || b_all !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: a=%h b=%h want all 0", a_all, b_all);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_overflow();
        run_exc(1'b1, 1'b0, 1'b0, 32'h0000_0010, 8'h40, 1'b0, 1'b0, "overflow");
    endtask

    task automatic test_priority();
        run_exc(1'b0, 1'b1, 1'b1, 32'h0000_1000, 8'h5A, 1'b0, 1'b0, "prio_dz_opc");
        run_exc(1'b1, 1'b1, 1'b1, 32'h0040_0020, 8'h33, 1'b0, 1'b0, "prio_all");
    endtask

    task automatic test_latency3();
        run_exc(1'b0, 1'b0, 1'b1, 32'h0000_0200, 8'hC3, 1'b1, 1'b0, "lat3_opc");
    endtask

    task automatic test_busy_ignore();
        run_exc(1'b1, 1'b0, 1'b0, 32'h0000_0100, 8'h21, 1'b0, 1'b1, "busy_ignore_a");
        run_exc(1'b0, 1'b1, 1'b0, 32'h0000_0300, 8'h7E, 1'b1, 1'b0, "busy_ignore_b_pre");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        div_zero = 1'b1; pc_in = 32'h0000_0800;
        mem_rdata_b = 32'hAB00_0000;
        @(posedge clk); #1;
        div_zero = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (b_all !== '0 || a_all !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait outputs: a=%h b=%h want all 0", a_all, b_all);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (b_pc_we !== 1'b0 || b_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_wait hold %0d: pc_we=%b busy=%b want 0 0",
                         i, b_pc_we, b_busy);
            end
        end
        reset_n = 1'b1;
        run_exc(1'b0, 1'b1, 1'b0, 32'h0000_0804, 8'h66, 1'b1, 1'b0, "after_reset_dz");
    endtask

    task automatic test_wrap();
        run_exc(1'b1, 1'b0, 1'b0, 32'h0000_0000, 8'hFF, 1'b0, 1'b0, "wrap_ff");
    endtask

    task automatic test_random();
        logic [2:0] req;
        for (int i = 0; i < 16; i++) begin
            req = 3'($urandom_range(1, 7));
            run_exc(req[2], req[1], req[0], $urandom, 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_priority();
        test_latency3();
        test_busy_ignore();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
